// File: rtl/sleep_arb_pkg.sv
// Shared types and constants for the sleep_arbiter block.
package sleep_arb_pkg;

  localparam int MS_W_DEF = 32;
  localparam int NREQ_MAX = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sleep_arb_pick.sv
// Combinational winner selection over the pending requesters.
// SLEEP_ARB_RR_EN selects round-robin from i_rr_ptr; otherwise the lowest index wins.
module sleep_arb_pick
  import sleep_arb_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  i_pending,
`ifdef SLEEP_ARB_RR_EN
  input  logic [IDX_W-1:0] i_rr_ptr,
`endif
  output logic [NREQ-1:0]  o_onehot,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  logic [IDX_W-1:0] w_cand;
`ifdef SLEEP_ARB_RR_EN
  logic [IDX_W:0]   w_sum;
`endif

  always_comb begin
    o_onehot = '0;
    o_idx    = '0;
    o_any    = 1'b0;
    w_cand   = '0;
`ifdef SLEEP_ARB_RR_EN
    w_sum    = '0;
`endif
    for (int k = 0; k < NREQ; k++) begin
`ifdef SLEEP_ARB_RR_EN
      // Wrap explicitly so non-power-of-two NREQ still rotates correctly.
      w_sum = {1'b0, i_rr_ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(NREQ)) w_sum = w_sum - (IDX_W+1)'(NREQ);
      w_cand = w_sum[IDX_W-1:0];
`else
      w_cand = IDX_W'(k);
`endif
      if (!o_any && i_pending[w_cand]) begin
        o_any            = 1'b1;
        o_onehot[w_cand] = 1'b1;
        o_idx            = w_cand;
      end
    end
  end

endmodule

// File: rtl/sleep_arbiter.sv
// Shares one downstream sleep unit among NREQ callers, one queued call per caller.
// Build option SLEEP_ARB_RR_EN: round-robin arbitration (default build: fixed priority).
module sleep_arbiter
  import sleep_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int MS_W = MS_W_DEF
) (
  input  logic                 __clk,
  input  logic                 __reset,
  input  logic [NREQ*MS_W-1:0] __p_ms,
  input  logic [NREQ-1:0]      __start,
  output logic [NREQ-1:0]      __valid,
  output logic [NREQ-1:0]      __idle,
  output logic [MS_W-1:0]      m_p_ms,
  output logic                 m_start,
  input  logic                 m_valid,
  input  logic                 m_idle,
  output logic [NREQ-1:0]      grant,
  output state_t               o_dbg_state
);

  localparam int IDX_W = idx_w(NREQ);

  // Handshake: a caller's __start is taken only while its __idle is high; the
  // call then completes with a one-cycle __valid and __idle rises the cycle after.
  // Downstream sees a one-cycle m_start and is only issued to while m_idle is high.

  state_t           r_state;
  logic [MS_W-1:0]  r_ms_q [NREQ];
  logic [NREQ-1:0]  r_pending;
  logic [NREQ-1:0]  r_valid;
  logic [NREQ-1:0]  r_idle;
  logic [NREQ-1:0]  r_grant;
  logic [MS_W-1:0]  r_m_p_ms;
  logic             r_m_start;
  logic [IDX_W-1:0] r_win;
`ifdef SLEEP_ARB_RR_EN
  logic [IDX_W-1:0] r_rr_ptr;
`endif

  logic [NREQ-1:0]  w_onehot;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;

  sleep_arb_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .i_pending (r_pending),
`ifdef SLEEP_ARB_RR_EN
    .i_rr_ptr  (r_rr_ptr),
`endif
    .o_onehot  (w_onehot),
    .o_idx     (w_idx),
    .o_any     (w_any)
  );

  always_ff @(posedge __clk) begin
    if (__reset) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_valid   <= '0;
      r_idle    <= '1;
      r_grant   <= '0;
      r_m_p_ms  <= '0;
      r_m_start <= 1'b0;
      r_win     <= '0;
`ifdef SLEEP_ARB_RR_EN
      r_rr_ptr  <= '0;
`endif
      for (int i = 0; i < NREQ; i++) r_ms_q[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Arbitrate over pending as registered; this cycle's captures wait a cycle.
          if (w_any && m_idle) begin
            r_grant   <= w_onehot;
            r_win     <= w_idx;
            r_m_p_ms  <= r_ms_q[w_idx];
            r_m_start <= 1'b1;
`ifdef SLEEP_ARB_RR_EN
            r_rr_ptr  <= (w_idx == IDX_W'(NREQ-1)) ? '0 : w_idx + IDX_W'(1);
`endif
            r_state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_m_start <= 1'b0;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (m_valid) begin
            r_valid[r_win]   <= 1'b1;
            r_pending[r_win] <= 1'b0;
            r_grant          <= '0;
            r_state          <= S_DONE;
          end
        end
        S_DONE: begin
          r_valid[r_win] <= 1'b0;
          r_idle[r_win]  <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // The winner's idle is low until S_DONE, so capture never collides with the FSM.
      for (int i = 0; i < NREQ; i++) begin
        if (__start[i] && r_idle[i]) begin
          r_ms_q[i]    <= __p_ms[i*MS_W +: MS_W];
          r_pending[i] <= 1'b1;
          r_idle[i]    <= 1'b0;
        end
      end
    end
  end

  assign __valid     = r_valid;
  assign __idle      = r_idle;
  assign m_p_ms      = r_m_p_ms;
  assign m_start     = r_m_start;
  assign grant       = r_grant;
  assign o_dbg_state = r_state;

endmodule
